// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind an SPI slave: 10-bit {cmd, payload}
// words latch addresses, write bytes, or return a byte on tx_data/tx_valid.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    logic [7:0]           mem [MEM_DEPTH];
    logic                 rx_valid_q;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;

    logic                 accept;
    cmd_e                 cmd;
    logic [7:0]           payload;
    logic                 wr_in_range;
    logic                 rd_in_range;

    // One command per rx_valid high period: only the rising edge is decoded.
    assign accept      = rx_valid & ~rx_valid_q;
    assign cmd         = cmd_e'(rx_data[9:8]);
    assign payload     = rx_data[7:0];
    assign wr_in_range = int'(wr_addr) < MEM_DEPTH;
    assign rd_in_range = int'(rd_addr) < MEM_DEPTH;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            if (accept) begin
                tx_valid <= 1'b0;
                unique case (cmd)
                    CMD_WR_ADDR: wr_addr <= payload[ADDR_SIZE-1:0];
                    CMD_WR_DATA: ;
                    CMD_RD_ADDR: rd_addr <= payload[ADDR_SIZE-1:0];
                    CMD_RD_DATA: begin
                        tx_data  <= rd_in_range ? mem[rd_addr] : 8'h00;
                        tx_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

    // NOTE: the array has no reset so it maps onto plain RAM; its contents are
    // undefined until written.
    always_ff @(posedge clk) begin
        if (accept && cmd == CMD_WR_DATA && wr_in_range)
            mem[wr_addr] <= payload;
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Randomized self-checking bench for spi_ram_ctrl: a full-depth instance and a
// MEM_DEPTH=200 instance share stimulus and are compared to an array model.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data_f, tx_data_s;
    logic       tx_valid_f, tx_valid_s;

    int checks = 0;
    int errors = 0;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut_full (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data_f), .tx_valid(tx_valid_f)
    );

    spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8)) dut_small (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data_s), .tx_valid(tx_valid_s)
    );

    always #5 clk = ~clk;

    // Reference model: byte arrays plus the two address pointers.
    logic [7:0] mem_f [256];
    logic [7:0] mem_s [256];
    logic [7:0] m_wr, m_rd;
    logic [7:0] exp_data_f, exp_data_s;
    logic       exp_valid;

    // Outputs captured one cycle after the accepting edge.
    logic [7:0] lat_data_f, lat_data_s;
    logic       lat_valid_f, lat_valid_s;

    task automatic model_reset();
        m_wr = 8'h00; m_rd = 8'h00;
        exp_data_f = 8'h00; exp_data_s = 8'h00; exp_valid = 1'b0;
    endtask

    task automatic model_apply(input logic [1:0] cmd, input logic [7:0] pl);
        exp_valid = 1'b0;
        case (cmd)
            2'b00: m_wr = pl;
            2'b01: begin
                mem_f[m_wr] = pl;
                if (m_wr < 8'd200) mem_s[m_wr] = pl;
            end
            2'b10: m_rd = pl;
            default: begin
                exp_data_f = mem_f[m_rd];
                exp_data_s = (m_rd < 8'd200) ? mem_s[m_rd] : 8'h00;
                exp_valid  = 1'b1;
            end
        endcase
    endtask

    // Starts and ends on a falling edge; rx_valid held `hold` cycles, low `low` cycles.
    task automatic send_cmd(input logic [1:0] cmd, input logic [7:0] pl,
                            input int hold, input int low);
        model_apply(cmd, pl);
        rx_data  = {cmd, pl};
        rx_valid = 1'b1;
        @(negedge clk);
        lat_data_f = tx_data_f; lat_valid_f = tx_valid_f;
        lat_data_s = tx_data_s; lat_valid_s = tx_valid_s;
        repeat (hold - 1) @(negedge clk);
        rx_valid = 1'b0;
        repeat (low) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (tx_valid_f !== 1'b0 || tx_data_f !== 8'h00) begin
            errors++;
            $display("FAIL reset_full: tx_valid=%b tx_data=%h, want 0/00", tx_valid_f, tx_data_f);
        end
        checks++;
        if (tx_valid_s !== 1'b0 || tx_data_s !== 8'h00) begin
            errors++;
            $display("FAIL reset_small: tx_valid=%b tx_data=%h, want 0/00", tx_valid_s, tx_data_s);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill();
        for (int a = 0; a < 256; a++) begin
            send_cmd(2'b00, 8'(a), 1, 1);
            send_cmd(2'b01, 8'($urandom_range(255)), 1, 1);
        end
        checks++;
        if (tx_valid_f !== 1'b0 || tx_valid_s !== 1'b0) begin
            errors++;
            $display("FAIL fill_no_valid: tx_valid full=%b small=%b, want 0", tx_valid_f, tx_valid_s);
        end
    endtask

    task automatic test_basic();
        send_cmd(2'b00, 8'h3A, 1, 1);
        send_cmd(2'b01, 8'h5C, 2, 1);
        send_cmd(2'b10, 8'h3A, 1, 2);
        checks++;
        if (tx_valid_f !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_low: tx_valid=%b, want 0", tx_valid_f);
        end
        send_cmd(2'b11, 8'h00, 1, 1);
        checks++;
        if (lat_valid_f !== 1'b1 || lat_data_f !== 8'h5C) begin
            errors++;
            $display("FAIL basic_read: tx_valid=%b tx_data=%h, want 1/5c", lat_valid_f, lat_data_f);
        end
    endtask

    task automatic test_clear();
        send_cmd(2'b00, 8'h10, 3, 1);
        checks++;
        if (lat_valid_f !== 1'b0 || lat_data_f !== 8'h5C) begin
            errors++;
            $display("FAIL clear_valid: tx_valid=%b tx_data=%h, want 0/5c", lat_valid_f, lat_data_f);
        end
    endtask

    task automatic test_hold_high();
        send_cmd(2'b00, 8'h05, 1, 1);
        model_apply(2'b01, 8'h11);
        rx_data  = 10'h111;
        rx_valid = 1'b1;
        repeat (6) @(negedge clk);
        rx_data = 10'h122;
        repeat (6) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        send_cmd(2'b10, 8'h05, 1, 1);
        send_cmd(2'b11, 8'h77, 1, 1);
        checks++;
        if (lat_valid_f !== 1'b1 || lat_data_f !== 8'h11) begin
            errors++;
            $display("FAIL hold_single_write: tx_valid=%b tx_data=%h, want 1/11", lat_valid_f, lat_data_f);
        end
    endtask

    task automatic test_wrap_and_range();
        send_cmd(2'b00, 8'hFF, 1, 1);
        send_cmd(2'b01, 8'hAA, 1, 1);
        send_cmd(2'b10, 8'hFF, 1, 1);
        send_cmd(2'b11, 8'h00, 1, 1);
        checks++;
        if (lat_valid_f !== 1'b1 || lat_data_f !== 8'hAA) begin
            errors++;
            $display("FAIL wrap_read_ff: tx_valid=%b tx_data=%h, want 1/aa", lat_valid_f, lat_data_f);
        end
        checks++;
        if (lat_valid_s !== 1'b1 || lat_data_s !== 8'h00) begin
            errors++;
            $display("FAIL small_read_ff: tx_valid=%b tx_data=%h, want 1/00", lat_valid_s, lat_data_s);
        end
        send_cmd(2'b00, 8'hF0, 1, 1);
        send_cmd(2'b01, 8'h3C, 1, 1);
        send_cmd(2'b10, 8'hF0, 1, 1);
        send_cmd(2'b11, 8'h00, 1, 1);
        checks++;
        if (lat_valid_s !== 1'b1 || lat_data_s !== 8'h00 || lat_data_f !== 8'h3C) begin
            errors++;
            $display("FAIL range_f0: small=%b/%h full=%h, want 1/00 and 3c",
                     lat_valid_s, lat_data_s, lat_data_f);
        end
        send_cmd(2'b00, 8'hC7, 1, 1);
        send_cmd(2'b01, 8'h9E, 1, 1);
        send_cmd(2'b10, 8'hC7, 1, 1);
        send_cmd(2'b11, 8'h00, 1, 1);
        checks++;
        if (lat_data_s !== 8'h9E) begin
            errors++;
            $display("FAIL small_last_in_range: tx_data=%h, want 9e", lat_data_s);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] dummy;
        send_cmd(2'b10, 8'hFF, 1, 1);
        send_cmd(2'b11, 8'h00, 1, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tx_valid_f !== 1'b0 || tx_data_f !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: tx_valid=%b tx_data=%h, want 0/00", tx_valid_f, tx_data_f);
        end
        model_reset();
        dummy = 8'($urandom_range(255));
        model_apply(2'b11, dummy);
        rx_data  = {2'b11, dummy};
        rx_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_valid_f !== 1'b1 || tx_data_f !== exp_data_f) begin
            errors++;
            $display("FAIL read_after_reset: tx_valid=%b tx_data=%h, want 1/%h",
                     tx_valid_f, tx_data_f, exp_data_f);
        end
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        send_cmd(2'b00, 8'h42, 1, 1);
        send_cmd(2'b01, 8'h01, 1, 1);
        send_cmd(2'b01, 8'h02, 1, 1);
        send_cmd(2'b10, 8'h42, 1, 1);
        send_cmd(2'b11, 8'h00, 1, 1);
        checks++;
        if (lat_valid_f !== 1'b1 || lat_data_f !== 8'h02) begin
            errors++;
            $display("FAIL back_to_back: tx_valid=%b tx_data=%h, want 1/02", lat_valid_f, lat_data_f);
        end
    endtask

    task automatic test_random();
        logic [1:0] cmd;
        for (int i = 0; i < 300; i++) begin
            cmd = 2'($urandom_range(3));
            send_cmd(cmd, 8'($urandom_range(255)), int'($urandom_range(1, 4)),
                     int'($urandom_range(1, 3)));
            checks++;
            if (lat_valid_f !== exp_valid || lat_data_f !== exp_data_f ||
                tx_valid_f !== exp_valid || tx_data_f !== exp_data_f) begin
                errors++;
                $display("FAIL random_full[%0d] cmd=%0d: tx=%b/%h, want %b/%h",
                         i, cmd, lat_valid_f, lat_data_f, exp_valid, exp_data_f);
            end
            checks++;
            if (lat_valid_s !== exp_valid || lat_data_s !== exp_data_s) begin
                errors++;
                $display("FAIL random_small[%0d] cmd=%0d: tx=%b/%h, want %b/%h",
                         i, cmd, lat_valid_s, lat_data_s, exp_valid, exp_data_s);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_clear();
        test_hold_high();
        test_wrap_and_range();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Single-port RAM with command decoder. It sits directly downstream of the SPI slave: it consumes that block's 10-bit rx_data/rx_valid words and returns read data on tx_data/tx_valid, which the SPI slave shifts out on MISO. It turns the SPI 2-bit command prefix into address-latch, write and read operations on an internal memory array.

Parameters:
MEM_DEPTH, 256, number of 8-bit words in the array
ADDR_SIZE, 8, address width; must satisfy 2**ADDR_SIZE >= MEM_DEPTH and ADDR_SIZE <= 8

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
rx_data  input  10  command word from the SPI slave: [9:8] = cmd, [7:0] = payload
rx_valid  input  1  rx_data valid; may stay high for many cycles per word
tx_data  output  8  read data returned to the SPI slave
tx_valid  output  1  tx_data holds valid read data

Behaviour:
- Reset (rst=1, asynchronous): tx_data=0, tx_valid=0, wr_addr=0, rd_addr=0, rx_valid_q=0. Memory contents are not reset.
- Edge detect: register rx_valid into rx_valid_q every cycle. A command is accepted only on the edge where rx_valid=1 and rx_valid_q=0.
- Accept rule: exactly one command per rx_valid high period. rx_data changes while rx_valid stays high are ignored. A new command needs rx_valid low for at least one sampled cycle.
- Decode on the accepting edge. Effects are visible right after that edge (latency 1 clk):
  - cmd 2'b00 (write address): wr_addr <= payload[ADDR_SIZE-1:0]. tx_valid <= 0.
  - cmd 2'b01 (write data): mem[wr_addr] <= payload. wr_addr unchanged. tx_valid <= 0.
  - cmd 2'b10 (read address): rd_addr <= payload[ADDR_SIZE-1:0]. tx_valid <= 0.
  - cmd 2'b11 (read data): payload is a dummy and is ignored. tx_data <= mem[rd_addr]. tx_valid <= 1. rd_addr unchanged.
- tx_valid hold: once set, tx_valid and tx_data stay stable until the next accepted command, which clears tx_valid (or reloads it on cmd 11). No timeout.
- Write-then-read to the same address: a read-data command accepted after a write-data command to that address returns the new value. Commands are always at least 2 cycles apart, so no bypass is needed.
- Out-of-range address (address >= MEM_DEPTH when MEM_DEPTH < 2**ADDR_SIZE):
  - a write is dropped and the memory is unchanged;
  - a read returns 8'h00 with tx_valid=1.
- Payload bits above ADDR_SIZE in address commands are ignored.
- Reset mid-operation: all registers return to their reset values immediately. tx_valid drops asynchronously. The next command is accepted only on a fresh rx_valid rising edge after rst deasserts. If rx_valid is already high at deassertion, that counts as a rising edge, because rx_valid_q resets to 0.
- Read data command before any read address command: reads mem[0], since rd_addr resets to 0.
- No internal FSM beyond the edge detector. Decode is purely a function of cmd on the accepting edge.

Test Plan:
1. Reset, then pulse rx_valid with 10'h0_3A (wr addr 0x3A), then 10'h1_5C (wr data 0x5C), then 10'h2_3A (rd addr), then 10'h3_00 (rd data) -> tx_data=8'h5C and tx_valid=1 one cycle after the 4th rx_valid rising edge. tx_valid stays 0 after the first three commands.
2. Hold rx_valid high for 12 cycles with rx_data=10'h1_11 at wr_addr=0x05, changing rx_data to 10'h1_22 mid-pulse -> mem[0x05]=8'h11 only; exactly one write occurs.
3. After test 1, send 10'h0_10 (wr addr) -> tx_valid falls to 0 one cycle after that rx_valid rising edge; tx_data remains 8'h5C.
4. Write 8'hAA to 0xFF, then issue rd addr 0xFF and rd data -> tx_data=8'hAA (wrap boundary). With MEM_DEPTH=200: a write to 0xF0 is dropped, and a read of 0xF0 returns 8'h00 with tx_valid=1.
5. Assert rst asynchronously between clock edges while tx_valid=1 -> tx_valid=0 and tx_data=0 before the next clk edge. A subsequent rd data command returns mem[0].
6. Back-to-back commands with rx_valid low for exactly 1 cycle between them (wr data 0x01, then wr data 0x02, same wr_addr) -> both accepted; the final mem value is 8'h02.
